// File: rtl/ex_pkg.sv
// ex_pkg: encodings shared by the execute stage and ControlUnit, plus the branch-condition helper.
package ex_pkg;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_MUL
   } aluOp_t;
   typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srcA_t;
   typedef enum logic [2:0] {SRCB_RS2, SRCB_LSJ, SRCB_UPPER, SRCB_FOUR} srcB_t;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mulState_t;
   function automatic logic branchTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, IF feedback and EX/MEM outputs of the execute stage.
interface ex_stage_if;
   logic [31:0] PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui;
   logic [3:0]  ALUControl;
   logic [1:0]  ALUSourceA;
   logic [2:0]  ALUSourceB, funct3;
   logic [4:0]  rd;
   logic        Branch, Jump, JumpReg, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT, InValid, MemStall;
   logic        PCsel, ExStall;
   logic [31:0] JumporBranch;
   logic [31:0] MEMALUOUT, MEMrs2val;
   logic [4:0]  MEMrd;
   logic        MEMRegWrite, MEMDmemREB, MEMDmemWEB, MEMDmem1ALUOUT, MEMValid;
   modport master (
      output PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui, ALUControl, ALUSourceA, ALUSourceB,
             funct3, rd, Branch, Jump, JumpReg, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT, InValid, MemStall,
      input  PCsel, ExStall, JumporBranch, MEMALUOUT, MEMrs2val, MEMrd, MEMRegWrite, MEMDmemREB,
             MEMDmemWEB, MEMDmem1ALUOUT, MEMValid
   );
   modport slave (
      input  PC, rs1val, rs2val, LoadStoreOrjalAddress, auipcOrlui, ALUControl, ALUSourceA, ALUSourceB,
             funct3, rd, Branch, Jump, JumpReg, RegWrite, DmemREB, DmemWEB, Dmem1ALUOUT, InValid, MemStall,
      output PCsel, ExStall, JumporBranch, MEMALUOUT, MEMrs2val, MEMrd, MEMRegWrite, MEMDmemREB,
             MEMDmemWEB, MEMDmem1ALUOUT, MEMValid
   );
endinterface

// File: rtl/ex_mul.sv
// ex_mul: 32-cycle shift-add multiplier returning the low word; holds DONE until the result is accepted.
module ex_mul
   import ex_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        accept,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   output logic        busy,
   output logic        done,
   output logic [31:0] product
);
   mulState_t state, nextState;
   logic [4:0] count;
   logic [31:0] mcand, mplier;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= IDLE;
         count <= '0;
         mcand <= '0;
         mplier <= '0;
         product <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && start) begin
            count <= '0;
            mcand <= opA;
            mplier <= opB;
            product <= '0;
         end else if (state == BUSY) begin
            count <= count + 5'd1;
            product <= product + (mplier[0] ? mcand : '0);
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
         end
      end
   always_comb begin
      nextState = state;
      nextState = (state == IDLE && start) ? BUSY :
                  (state == BUSY && count == 5'd31) ? DONE :
                  (state == DONE && accept) ? IDLE : state;
   end
   assign busy = state == BUSY;
   assign done = state == DONE;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand select, ALU, branch/jump resolution and the EX/MEM pipeline register.
module ex_stage
   import ex_pkg::*;
(
   input logic       CLK,
   input logic       RST,
   ex_stage_if.slave bus
);
   logic [31:0] opA, opB, aluOut, product;
   logic mulStart, mulBusy, mulDone, mulStall, stall;
   assign opA = bus.ALUSourceA == SRCA_RS1 ? bus.rs1val : bus.ALUSourceA == SRCA_PC ? bus.PC : '0;
   assign opB = bus.ALUSourceB == SRCB_RS2   ? bus.rs2val :
                bus.ALUSourceB == SRCB_LSJ   ? bus.LoadStoreOrjalAddress :
                bus.ALUSourceB == SRCB_UPPER ? bus.auipcOrlui :
                bus.ALUSourceB == SRCB_FOUR  ? 32'd4 : '0;
   always_comb begin
      aluOut = '0;
      case (aluOp_t'(bus.ALUControl))
         ALU_ADD:   aluOut = opA + opB;
         ALU_SUB:   aluOut = opA - opB;
         ALU_AND:   aluOut = opA & opB;
         ALU_OR:    aluOut = opA | opB;
         ALU_XOR:   aluOut = opA ^ opB;
         ALU_SLL:   aluOut = opA << opB[4:0];
         ALU_SRL:   aluOut = opA >> opB[4:0];
         ALU_SRA:   aluOut = $signed(opA) >>> opB[4:0];
         ALU_SLT:   aluOut = {31'd0, $signed(opA) < $signed(opB)};
         ALU_SLTU:  aluOut = {31'd0, opA < opB};
         ALU_PASSB: aluOut = opB;
         ALU_MUL:   aluOut = product;
         default:   aluOut = '0;
      endcase
   end
   // A MUL stalls from its first cycle until the multiplier sits in DONE
   assign mulStart = bus.InValid && bus.ALUControl == ALU_MUL && !mulBusy && !mulDone;
   assign mulStall = mulStart || mulBusy;
   assign stall = mulStall || bus.MemStall;
   assign bus.ExStall = !RST && stall;
   assign bus.PCsel = !RST && bus.InValid && !stall &&
                      (bus.Jump || (bus.Branch && branchTaken(bus.funct3, bus.rs1val, bus.rs2val)));
   assign bus.JumporBranch = bus.JumpReg ? (bus.rs1val + bus.LoadStoreOrjalAddress) & ~32'd1
                                         : bus.PC + bus.LoadStoreOrjalAddress;
   ex_mul mul (
      .CLK, .RST, .start(mulStart), .accept(!bus.MemStall), .opA, .opB,
      .busy(mulBusy), .done(mulDone), .product
   );
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         bus.MEMALUOUT <= '0;
         bus.MEMrs2val <= '0;
         bus.MEMrd <= '0;
         bus.MEMRegWrite <= 1'b0;
         bus.MEMDmemREB <= 1'b1;
         bus.MEMDmemWEB <= 1'b1;
         bus.MEMDmem1ALUOUT <= 1'b0;
         bus.MEMValid <= 1'b0;
      end else if (!bus.MemStall) begin
         if (mulStall) begin
            bus.MEMValid <= 1'b0;
            bus.MEMRegWrite <= 1'b0;
            bus.MEMDmemREB <= 1'b1;
            bus.MEMDmemWEB <= 1'b1;
         end else begin
            bus.MEMALUOUT <= aluOut;
            bus.MEMrs2val <= bus.rs2val;
            bus.MEMrd <= bus.rd;
            bus.MEMRegWrite <= bus.InValid && bus.RegWrite;
            bus.MEMDmemREB <= !bus.InValid || bus.DmemREB;
            bus.MEMDmemWEB <= !bus.InValid || bus.DmemWEB;
            bus.MEMDmem1ALUOUT <= bus.Dmem1ALUOUT;
            bus.MEMValid <= bus.InValid;
         end
      end
endmodule
